dcache_sram_nway: RTL

Parametrised N-way set-associative data-cache storage array. It is the successor to the fixed 2-way/16-set dcache array. It provides tag and data storage, combinational hit detection, true-LRU victim selection, and a per-write dirty control. It also adds a sequential flush engine that walks the whole array and streams dirty lines out over a valid/ready write-back port. It sits between the dcache controller and the memory interface.

---
 rtl/dcache_sram_nway.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data array with true-LRU victim choice
// and a flush engine that streams dirty lines out over a valid/ready port.
module dcache_sram_nway #(
   parameter  int WAYS   = 4,
   parameter  int SETS   = 16,
   parameter  int TAG_W  = 23,
   parameter  int LINE_W = 256,
   localparam int AW_WAY = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int SW     = $clog2(SETS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              write_i,
   input  logic              dirty_i,
   input  logic [SW-1:0]     addr_i,
   input  logic [TAG_W+1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              hit_o,
   output logic [AW_WAY-1:0] way_o,
   output logic [TAG_W+1:0]  tag_o,
   output logic [LINE_W-1:0] data_o,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              flush_done_o,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [SW-1:0]     wb_set_o,
   output logic [TAG_W-1:0]  wb_tag_o,
   output logic [LINE_W-1:0] wb_data_o
);

   localparam logic [AW_WAY-1:0] WMAX = AW_WAY'(WAYS - 1);
   localparam logic [SW-1:0]     SMAX = SW'(SETS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] data_q  [SETS][WAYS];
   logic [AW_WAY-1:0] age_q   [SETS][WAYS];

   state_t            state;
   logic [SW-1:0]     cur_set;
   logic [AW_WAY-1:0] cur_way;

   logic [AW_WAY-1:0] hit_way, inv_way, lru_way, acc_age;
   logic              inv_any, wr_en, lru_en, wb_ack, last, cur_dirty;
   logic              unused_tag;

   assign unused_tag = ^tag_i[TAG_W+1:TAG_W];

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      hit_o   = 1'b0;
      hit_way = '0;
      inv_any = 1'b0;
      inv_way = '0;
      lru_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[addr_i][w] &&
             tag_q[addr_i][w] == tag_i[TAG_W-1:0]) begin
            hit_o   = 1'b1;
            hit_way = AW_WAY'(w);
         end
         if (!valid_q[addr_i][w]) begin
            inv_any = 1'b1;
            inv_way = AW_WAY'(w);
         end
         if (age_q[addr_i][w] == WMAX) lru_way = AW_WAY'(w);
      end
   end

   assign way_o  = hit_o ? hit_way : (inv_any ? inv_way : lru_way);
   assign tag_o  = {valid_q[addr_i][way_o], dirty_q[addr_i][way_o],
                    tag_q[addr_i][way_o]};
   assign data_o = data_q[addr_i][way_o];

   assign acc_age   = age_q[addr_i][way_o];
   assign wr_en     = req_i & write_i & ~busy_o;
   assign lru_en    = wr_en | (req_i & ~write_i & hit_o & ~busy_o);
   assign wb_ack    = (state == OFFER) & wb_ready_i;
   assign last      = (cur_set == SMAX) && (cur_way == WMAX);
   assign cur_dirty = valid_q[cur_set][cur_way] & dirty_q[cur_set][cur_way];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               data_q[s][w] <= '0;
               age_q[s][w]  <= AW_WAY'(w);
            end
         end
      end else begin
         if (wr_en) begin
            valid_q[addr_i][way_o] <= 1'b1;
            dirty_q[addr_i][way_o] <= dirty_i;
            tag_q[addr_i][way_o]   <= tag_i[TAG_W-1:0];
            data_q[addr_i][way_o]  <= data_i;
         end
         if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW_WAY'(w) == way_o)
                  age_q[addr_i][w] <= '0;
               else if (age_q[addr_i][w] < acc_age)
                  age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
            end
         end
         if (wb_ack) dirty_q[cur_set][cur_way] <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         cur_set      <= '0;
         cur_way      <= '0;
         busy_o       <= 1'b0;
         flush_done_o <= 1'b0;
         wb_valid_o   <= 1'b0;
         wb_set_o     <= '0;
         wb_tag_o     <= '0;
         wb_data_o    <= '0;
      end else begin
         flush_done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (flush_i) begin
                  state   <= SCAN;
                  busy_o  <= 1'b1;
                  cur_set <= '0;
                  cur_way <= '0;
               end
            end
            SCAN: begin
               if (cur_dirty) begin
                  state      <= OFFER;
                  wb_valid_o <= 1'b1;
                  wb_set_o   <= cur_set;
                  wb_tag_o   <= tag_q[cur_set][cur_way];
                  wb_data_o  <= data_q[cur_set][cur_way];
               end else if (last) begin
                  state        <= DONE;
                  busy_o       <= 1'b0;
                  flush_done_o <= 1'b1;
               end else begin
                  cur_way <= (cur_way == WMAX) ? '0 : cur_way + 1'b1;
                  if (cur_way == WMAX) cur_set <= cur_set + 1'b1;
               end
            end
            OFFER: begin
               if (wb_ready_i) begin
                  wb_valid_o <= 1'b0;
                  if (last) begin
                     state        <= DONE;
                     busy_o       <= 1'b0;
                     flush_done_o <= 1'b1;
                  end else begin
                     state   <= SCAN;
                     cur_way <= (cur_way == WMAX) ? '0 : cur_way + 1'b1;
                     if (cur_way == WMAX) cur_set <= cur_set + 1'b1;
                  end
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end

endmodule
